adder_req_master: RTL

Synthesizable initiator for the `my_adder` operand/result interface. It accepts operand pairs from a host through a valid/ready port and buffers them in a small FIFO. It issues one pair at a time to the adder, samples the adder's sum and carry after a fixed latency, and checks them against an internal reference. It returns each result to the host with an error flag and keeps pass/fail counters. It sits on the driving side of `adder_if`, opposite `my_adder`.

---
 rtl/adder_req_master_if.sv | 40 ++++
 rtl/adder_req_master.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/adder_req_master_if.sv
// Operand/result bundle between the host, adder_req_master and my_adder.
// Handshake rule: a transfer happens on a rising clk edge where both valid
// and ready are high; valid must not depend on ready, and the payload must
// stay stable while valid is high and ready is low.
interface adder_req_master_if #(
    parameter int WIDTH = 4
) ();
    // host operand port
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    // adder side
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;
    // host result port
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_carry;
    logic             res_err;
    // status
    logic [7:0]       err_cnt;
    logic [15:0]      txn_cnt;
    logic             busy;

    modport master (
        input  in_valid, in_a, in_b, add_sum, add_carry, res_ready,
        output in_ready, add_a, add_b, res_valid, res_sum, res_carry,
               res_err, err_cnt, txn_cnt, busy
    );

    modport slave (
        output in_valid, in_a, in_b, add_sum, add_carry, res_ready,
        input  in_ready, add_a, add_b, res_valid, res_sum, res_carry,
               res_err, err_cnt, txn_cnt, busy
    );
endinterface

// File: rtl/adder_req_master.sv
// Initiator for my_adder: buffers host operand pairs in a FIFO, issues one
// pair at a time, samples the adder after ADDER_LAT cycles, checks the
// result against a local sum and hands it back to the host with an error flag.
module adder_req_master #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 4,
    parameter int ADDER_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    adder_req_master_if.master  bus,
    output logic [1:0]          dbg_state
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int CNT_W = (ADDER_LAT > 0) ? $clog2(ADDER_LAT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // FIFO storage; pointers carry one extra wrap bit to tell full from empty
    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic [2*WIDTH-1:0] rd_data;

    // FSM strobes
    logic pop;
    logic sample;
    logic take;

    logic [CNT_W-1:0] lat_cnt;
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;
    logic [WIDTH:0]   exp_total;
    logic             mismatch;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign push       = bus.in_valid && !fifo_full;
    assign rd_data    = mem[rd_ptr[AW-1:0]];

    assign bus.in_ready = !fifo_full;
    assign bus.busy     = !fifo_empty || (state != IDLE);
    assign dbg_state    = state;

    // Reference sum is formed at WIDTH+1 bits so the carry takes part in the check
    assign exp_total = {1'b0, exp_a} + {1'b0, exp_b};
    assign mismatch  = ({bus.add_carry, bus.add_sum} != exp_total);

    // FIFO data array: written on accepted pushes only, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {bus.in_a, bus.in_b};
        end
    end

    // FIFO pointers; reset flushes any queued pairs
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and strobes: pop in IDLE, sample when latency expires, release on res_ready
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        sample    = 1'b0;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    sample    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    take      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Issue registers and latency counter; add_a/add_b hold the last pair between transactions
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.add_a <= '0;
            bus.add_b <= '0;
            exp_a     <= '0;
            exp_b     <= '0;
            lat_cnt   <= '0;
        end else begin
            if (pop) begin
                bus.add_a <= rd_data[2*WIDTH-1:WIDTH];
                bus.add_b <= rd_data[WIDTH-1:0];
                exp_a     <= rd_data[2*WIDTH-1:WIDTH];
                exp_b     <= rd_data[WIDTH-1:0];
                lat_cnt   <= CNT_W'(ADDER_LAT);
            end else if ((state == WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - CNT_W'(1);
            end
        end
    end

    // Result capture, host release and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.res_valid <= 1'b0;
            bus.res_sum   <= '0;
            bus.res_carry <= 1'b0;
            bus.res_err   <= 1'b0;
            bus.err_cnt   <= '0;
            bus.txn_cnt   <= '0;
        end else begin
            if (sample) begin
                bus.res_valid <= 1'b1;
                bus.res_sum   <= bus.add_sum;
                bus.res_carry <= bus.add_carry;
                bus.res_err   <= mismatch;
                if (mismatch && (bus.err_cnt != 8'hFF)) begin
                    bus.err_cnt <= bus.err_cnt + 8'd1;
                end
            end
            if (take) begin
                bus.res_valid <= 1'b0;
                bus.txn_cnt   <= bus.txn_cnt + 16'd1;
            end
        end
    end
endmodule
